eac_post_normalizer: RTL
========================

# eac_post_normalizer

Pipelined post-adder normalization stage directly downstream of the end-around-carry CLA adder in the FMA datapath. It consumes the raw adder sum, carry-out and effective operation, and recovers sign and magnitude from the one's-complement/EAC result. It counts leading zeros, left-normalizes the mantissa and adjusts the exponent. Its output is a valid/ready stream to the rounding stage.

## Interface
- ADDER_WIDTH, 74, width of adder sum and normalized mantissa (3×24+2, single precision)
- EXP_WIDTH, 10, width of incoming biased exponent; output exponent is EXP_WIDTH+1 two's complement
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  adder result valid
- in_ready  output  1  stage can accept this cycle
- sum  input  ADDER_WIDTH  adder sum
- cout  input  1  adder carry-out
- effectiveOperation  input  1  1 = effective subtraction, 0 = addition
- sticky_in  input  1  alignment sticky bit
- sign_in  input  1  sign of larger-operand path
- exp_in  input  EXP_WIDTH  pre-normalization exponent
- out_valid  output  1  normalized result valid
- out_ready  input  1  downstream accepts
- mant_out  output  ADDER_WIDTH  normalized mantissa; MSB=1 unless zero_out
- exp_out  output  EXP_WIDTH+1  adjusted exponent, signed
- sign_out, sticky_out, zero_out  output  1 each  result sign, sticky, exact-zero flag

## Operation
- Magnitude recovery (stage 1):
  - Subtraction, cout=0: result negative; mag=~sum, sign=~sign_in, sticky=sticky_in.
  - Subtraction, cout=1: the adder already applied the end-around carry; mag=sum, sign=sign_in.
  - Addition, cout=1: overflow; mag={1'b1,sum[W-1:1]}, sticky=sticky_in|sum[0], exp_adj=+1.
  - Addition, cout=0: mag=sum, exp_adj=0.
- Leading-zero count lzc over mag, priority encoder, width clog2(ADDER_WIDTH+1), stage 1.
- Shift/adjust (final stage): mant_out=mag<<lzc; exp_out=sign-extended exp_in + exp_adj − lzc, no clamping; negative or zero exp_out is passed through for downstream denormal handling.
- Zero: mag==0 gives zero_out=1, mant_out=0, exp_out=0, and sign_out=0 (+0, RNE) when sticky=0. When sticky=1, sign_out keeps the computed sign.
- Pipeline register per stage holds valid plus payload; no state machine beyond per-stage valid bits.
- Handshake: a stage loads when its valid is 0 or the next stage takes its data. in_ready = ~s1_valid | s1_advance, combinational from out_ready. A transfer occurs on in_valid&in_ready and on out_valid&out_ready.
- Backpressure: out_ready=0 holds all outputs stable. Inputs are not consumed once the pipeline is full.
- Simultaneous accept and emit in one cycle sustains one result per cycle.

## Timing
- Latency: 2 cycles with the macro, 1 cycle without. Throughput 1/cycle with out_ready held at 1.
- Reset (asynchronous): all valid bits 0; out_valid=0, mant_out=0, exp_out=0, sign_out=0, sticky_out=0, zero_out=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight results are discarded and no out_valid pulse follows. Payload registers are cleared.
- Payload registers update only on load. mant_out and exp_out never change while out_valid=1 and out_ready=0.

## Configuration
- EAC_NORM_PIPE2_EN defined: two stages; register after magnitude recovery plus LZC, shift in stage 2; latency 2.
- EAC_NORM_PIPE2_EN undefined: recovery, LZC and shift in one combinational stage into the output register; latency 1. Handshake rules are identical.

## Test plan
Bench runs ADDER_WIDTH=16, EXP_WIDTH=8, in both macro settings.
- Addition, no overflow: sum=0x0F00, cout=0, exp_in=20 → mant_out=0xF000, exp_out=16, sign_out=sign_in.
- Addition, overflow: sum=0x0001, cout=1, exp_in=20 → mant_out=0x8000, exp_out=21, sticky_out=1.
- Negative subtraction: effectiveOperation=1, cout=0, sum=0xFFF0, sign_in=0 → mag=0x000F, mant_out=0xF000, exp_out=exp_in−12, sign_out=1.
- Exact cancellation: effectiveOperation=1, cout=1, sum=0x0000, sticky_in=0 → zero_out=1, sign_out=0, exp_out=0. With sticky_in=1: zero_out=1, sticky_out=1.
- Backpressure: stream 5 results, out_ready low for 3 cycles mid-stream → outputs held stable, in_ready drops once full, all 5 emitted in order, none duplicated.
- Reset with 2 results in flight → out_valid=0 next cycle, in_ready=1, and no stale output after release.

Source files
------------

// File: rtl/eac_post_normalizer_if.sv
// eac_post_normalizer_if: adder-result input stream and normalized-result output stream
interface eac_post_normalizer_if #(
  parameter int ADDER_WIDTH = 74,
  parameter int EXP_WIDTH = 10
);
  logic in_valid;
  logic in_ready;
  logic [ADDER_WIDTH-1:0] sum;
  logic cout;
  logic effectiveOperation;
  logic sticky_in;
  logic sign_in;
  logic [EXP_WIDTH-1:0] exp_in;
  logic out_valid;
  logic out_ready;
  logic [ADDER_WIDTH-1:0] mant_out;
  logic [EXP_WIDTH:0] exp_out;
  logic sign_out;
  logic sticky_out;
  logic zero_out;
  modport master (
    output in_valid, sum, cout, effectiveOperation, sticky_in, sign_in, exp_in, out_ready,
    input in_ready, out_valid, mant_out, exp_out, sign_out, sticky_out, zero_out
  );
  modport slave (
    input in_valid, sum, cout, effectiveOperation, sticky_in, sign_in, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out, sticky_out, zero_out
  );
endinterface

// File: rtl/eac_post_normalizer.sv
// eac_post_normalizer: EAC sum magnitude recovery, LZC, left-normalize and exponent adjust.
// EAC_NORM_PIPE2_EN defined: register after recovery+LZC (latency 2); else latency 1.
module eac_post_normalizer #(
  parameter int ADDER_WIDTH = 74,
  parameter int EXP_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  eac_post_normalizer_if.slave bus
);
  localparam int W = ADDER_WIDTH;
  localparam int LW = $clog2(ADDER_WIDTH + 1);
  localparam int EW = EXP_WIDTH + 1;
  localparam int PW = W + LW + EW + 3;
  logic [W-1:0] c_mag, p_mag;
  logic [LW-1:0] c_lzc, p_lzc;
  logic [EW-1:0] c_exp, p_exp;
  logic c_sgn, c_stk, c_adj, p_sgn, p_stk, p_z, p_valid, out_load;
  logic [PW-1:0] p_pay;
  wire sub_neg = bus.effectiveOperation & ~bus.cout;
  wire add_ovf = ~bus.effectiveOperation & bus.cout;
  // Negative subtraction takes the one's complement; addition overflow shifts the carry in.
  always_comb begin
    c_mag = sub_neg ? ~bus.sum : add_ovf ? {1'b1, bus.sum[W-1:1]} : bus.sum;
    c_sgn = sub_neg ? ~bus.sign_in : bus.sign_in;
    c_stk = bus.sticky_in | (add_ovf & bus.sum[0]);
    c_adj = add_ovf;
    c_exp = {bus.exp_in[EXP_WIDTH-1], bus.exp_in} + EW'(c_adj);
    c_lzc = LW'(W);
    for (int i = 0; i < W; i++) if (c_mag[i]) c_lzc = LW'(W - 1 - i);
  end
  assign out_load = ~bus.out_valid | bus.out_ready;
`ifdef EAC_NORM_PIPE2_EN
  logic s1_valid;
  logic [PW-1:0] s1_pay;
  assign bus.in_ready = ~s1_valid | out_load;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pay <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_pay <= {c_mag, c_lzc, c_exp, c_sgn, c_stk, ~|c_mag};
    end
  assign p_valid = s1_valid;
  assign p_pay = s1_pay;
`else
  assign bus.in_ready = out_load;
  assign p_valid = bus.in_valid;
  assign p_pay = {c_mag, c_lzc, c_exp, c_sgn, c_stk, ~|c_mag};
`endif
  assign {p_mag, p_lzc, p_exp, p_sgn, p_stk, p_z} = p_pay;
  // An exact zero becomes +0 unless sticky says the true result was nonzero.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.mant_out <= '0;
      bus.exp_out <= '0;
      bus.sign_out <= 1'b0;
      bus.sticky_out <= 1'b0;
      bus.zero_out <= 1'b0;
    end else if (out_load) begin
      bus.out_valid <= p_valid;
      if (p_valid) begin
        bus.mant_out <= p_z ? '0 : p_mag << p_lzc;
        bus.exp_out <= p_z ? '0 : p_exp - EW'(p_lzc);
        bus.sign_out <= p_sgn & ~(p_z & ~p_stk);
        bus.sticky_out <= p_stk;
        bus.zero_out <= p_z;
      end
    end
endmodule
